red_pitaya_iq_na_sweep: RTL and testbench
=========================================

# red_pitaya_iq_na_sweep

Network-analyzer sweep sequencer sitting directly downstream of the IQ demodulator block. It consumes the low-pass-filtered quadratures, steps the IQ reference frequency word point by point, waits a settling time, and accumulates a fixed number of samples per point. Per-point I/Q sums go into a result FIFO that the PS drains over the system bus, so a whole sweep runs without per-point CPU interaction.

## Interface
Parameters:
- LPFBITS, 24, width of signed input quadratures
- PHASEBITS, 32, frequency (phase increment) word width
- SUMBITS, 62, signed accumulator width per quadrature
- FIFOLOG2, 4, log2 of result FIFO depth (entries of {i_sum,q_sum})

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset; synchronous, active-high
- quadrature1_i  in  LPFBITS  signed filtered I quadrature
- quadrature2_i  in  LPFBITS  signed filtered Q quadrature
- freq_o  out  PHASEBITS  frequency word driven to the IQ fgen
- freq_valid_o  out  1  one-cycle pulse when freq_o changes
- busy_o  out  1  sweep in progress
- addr  in  16  bus address
- wen  in  1  bus write strobe
- ren  in  1  bus read strobe
- ack  out  1  bus acknowledge
- rdata  out  32  bus read data
- wdata  in  32  bus write data

## Operation
- Register map: 0x100 ctrl (W bit0 start, bit1 abort; both self-clearing; R: state); 0x104 start_freq; 0x108 step_freq; 0x10C points[15:0]; 0x110 averages; 0x114 sleepcycles; 0x118 status R ({25: fifo_full, 24: busy, 23:16 fifo_count, 15:0 point_index}); 0x120/0x124 head i_sum low/high; 0x128/0x12C head q_sum low/high (sign-extended to 64); 0x200 FIFOLOG2. Other addresses read 0.
- FSM: IDLE -> SETTLE -> AVERAGE -> STORE -> (SETTLE or IDLE).
- IDLE: start with points!=0 flushes FIFO, point_index=0, freq_o=start_freq, pulse freq_valid_o, -> SETTLE. start with points==0 ignored.
- SETTLE: count sleepcycles cycles; sleepcycles=0 -> AVERAGE next cycle. Sums cleared on entry.
- AVERAGE: each cycle sum += sign-extended quadrature; averages=0 treated as 1.
- STORE: if FIFO not full, push {i_sum,q_sum}; then if point_index==points-1 -> IDLE, else point_index++, freq_o += step_freq (mod 2^PHASEBITS, wraps silently), pulse freq_valid_o, -> SETTLE. If FIFO full: stall in STORE, freq_o held, no data lost.
- FIFO pop: a read of 0x12C when not empty pops after returning data; read when empty returns 0, no pop.
- abort: any state -> IDLE next cycle, partial sums discarded, FIFO contents kept. abort and start same write: abort wins.
- start while busy: restarts sweep (FIFO flushed).
- Registers writable anytime; values sampled at point boundaries (step_freq at STORE, sleepcycles at SETTLE entry, averages at AVERAGE entry).

## Timing
- Reset values: freq_o 0, freq_valid_o 0, busy_o 0, ack 0, rdata 0, all config registers 0, FIFO empty, state IDLE.
- ack <= wen|ren registered, rdata valid same cycle as ack (1-cycle latency).
- Start write at cycle N: freq_o/freq_valid_o update at N+1; first accumulated sample at N+2+sleepcycles.
- Per point: 1 (SETTLE entry) + sleepcycles + averages + 1 (STORE) cycles when FIFO not full.
- busy_o high from the cycle after start until return to IDLE.
- Simultaneous push and pop: both happen, count unchanged.

## Configuration
- IQ_NA_SWEEP_LOOP_EN defined: ctrl bit2 (loop) is implemented; after last point with loop=1, freq_o reloads start_freq, point_index=0, sweep repeats until abort; FIFO not flushed between passes.
- Undefined: bit2 ignored, reads 0; sweep always ends in IDLE.

## Structure
- Package red_pitaya_iq_na_pkg: FSM state encoding, register offset constants, ctrl bit positions.
- Sub-module red_pitaya_iq_na_fifo: synchronous FIFO, width 2*SUMBITS, depth 2^FIFOLOG2, full/empty/count outputs, first-word-fall-through.

## Test plan
- start_freq=1000, step=10, points=3, sleep=2, averages=4, quadratures const 5/-3 -> freq_o 1000,1010,1020; FIFO 3 entries each i=20, q=-12; busy_o falls after third STORE.
- points=0, start -> stays IDLE, freq_valid_o never pulses.
- FIFOLOG2=2, points=6, no reads -> stall in STORE at point 4 with freq_o held; pop one entry -> sweep resumes, final count 4.
- start_freq=0xFFFFFFF0, step=0x20 -> second freq_o 0x00000010.
- abort during AVERAGE of point 2 -> IDLE next cycle, FIFO holds 1 entry; read 0x12C twice -> second read returns 0, count 0.
- With IQ_NA_SWEEP_LOOP_EN, loop=1, points=2 -> freq_o sequence start, start+step, start, ... until abort.

Source files
------------

// File: rtl/red_pitaya_iq_na_pkg.sv
// Shared definitions for the IQ network-analyzer sweep sequencer: FSM states,
// bus register offsets and ctrl bit positions.
package red_pitaya_iq_na_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_AVERAGE = 2'd2,
      ST_STORE   = 2'd3
   } na_state_e;

   localparam logic [15:0] ADDR_CTRL    = 16'h0100;
   localparam logic [15:0] ADDR_START   = 16'h0104;
   localparam logic [15:0] ADDR_STEP    = 16'h0108;
   localparam logic [15:0] ADDR_POINTS  = 16'h010C;
   localparam logic [15:0] ADDR_AVG     = 16'h0110;
   localparam logic [15:0] ADDR_SLEEP   = 16'h0114;
   localparam logic [15:0] ADDR_STATUS  = 16'h0118;
   localparam logic [15:0] ADDR_HEAD_IL = 16'h0120;
   localparam logic [15:0] ADDR_HEAD_IH = 16'h0124;
   localparam logic [15:0] ADDR_HEAD_QL = 16'h0128;
   localparam logic [15:0] ADDR_HEAD_QH = 16'h012C;
   localparam logic [15:0] ADDR_LOG2    = 16'h0200;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_LOOP  = 2;

   // averages==0 behaves as one sample; returns the down-counter preload
   function automatic logic [31:0] avg_preload(input logic [31:0] averages);
      return (averages == 32'd0) ? 32'd0 : (averages - 32'd1);
   endfunction

endpackage

// File: rtl/red_pitaya_iq_na_fifo.sv
// Synchronous first-word-fall-through FIFO holding per-point {i_sum,q_sum} results.
module red_pitaya_iq_na_fifo
   import red_pitaya_iq_na_pkg::*;
#(
   parameter int WIDTH = 124,
   parameter int LOG2  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LOG2:0]    o_count
);
   localparam int DEPTH = 1 << LOG2;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [LOG2-1:0]  r_wptr;
   logic [LOG2-1:0]  r_rptr;
   logic [LOG2:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (LOG2+1)'(DEPTH));
   assign o_empty   = (r_count == (LOG2+1)'(0));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wptr  <= LOG2'(0);
         r_rptr  <= LOG2'(0);
         r_count <= (LOG2+1)'(0);
      end else begin
         if (w_do_push) r_wptr <= r_wptr + LOG2'(1);
         if (w_do_pop)  r_rptr <= r_rptr + LOG2'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (LOG2+1)'(1);
            2'b01:   r_count <= r_count - (LOG2+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // storage has no reset; pointers alone define validity
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/red_pitaya_iq_na_sweep.sv
// Network-analyzer sweep sequencer: steps the IQ frequency word, settles, averages,
// and queues per-point I/Q sums. Optional sweep looping via IQ_NA_SWEEP_LOOP_EN.
module red_pitaya_iq_na_sweep
   import red_pitaya_iq_na_pkg::*;
#(
   parameter int LPFBITS   = 24,
   parameter int PHASEBITS = 32,
   parameter int SUMBITS   = 62,
   parameter int FIFOLOG2  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [LPFBITS-1:0]   quadrature1_i,
   input  logic [LPFBITS-1:0]   quadrature2_i,
   output logic [PHASEBITS-1:0] freq_o,
   output logic                 freq_valid_o,
   output logic                 busy_o,
   input  logic [15:0]          addr,
   input  logic                 wen,
   input  logic                 ren,
   output logic                 ack,
   output logic [31:0]          rdata,
   input  logic [31:0]          wdata
);
   na_state_e              r_state, w_state_nxt;
   logic [PHASEBITS-1:0]   r_start_freq, r_step_freq, r_freq;
   logic [15:0]            r_points, r_idx;
   logic [31:0]            r_averages, r_sleep, r_cnt;
   logic [SUMBITS-1:0]     r_isum, r_qsum, w_qi_ext, w_qq_ext;
   logic                   r_freq_valid, r_busy, r_ack;
   logic [31:0]            r_rdata, w_rdata_nxt;
   logic                   w_start, w_abort, w_loop, w_last;
   logic                   w_restart, w_reload, w_step, w_enter_settle, w_enter_avg;
   logic                   w_cnt_dec, w_acc, w_push, w_pop;
   logic                   w_fifo_full, w_fifo_empty;
   logic [FIFOLOG2:0]      w_fifo_count;
   logic [2*SUMBITS-1:0]   w_fifo_rdata;
   logic [63:0]            w_head_i, w_head_q;

   assign w_start  = wen && (addr == ADDR_CTRL) && wdata[CTRL_START];
   assign w_abort  = wen && (addr == ADDR_CTRL) && wdata[CTRL_ABORT];
   assign w_pop    = ren && (addr == ADDR_HEAD_QH) && !w_fifo_empty;
   assign w_last   = (r_idx == (r_points - 16'd1));
   assign w_qi_ext = {{(SUMBITS-LPFBITS){quadrature1_i[LPFBITS-1]}}, quadrature1_i};
   assign w_qq_ext = {{(SUMBITS-LPFBITS){quadrature2_i[LPFBITS-1]}}, quadrature2_i};

`ifdef IQ_NA_SWEEP_LOOP_EN
   logic r_loop;
   always_ff @(posedge clk_i) begin
      if (rst_i) r_loop <= 1'b0;
      else if (wen && (addr == ADDR_CTRL)) r_loop <= wdata[CTRL_LOOP];
      else r_loop <= r_loop;
   end
   assign w_loop = r_loop;
`else
   assign w_loop = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   // abort outranks start; a start with zero points is simply dropped
   always_comb begin
      w_state_nxt    = r_state;
      w_restart      = 1'b0;
      w_reload       = 1'b0;
      w_step         = 1'b0;
      w_enter_settle = 1'b0;
      w_enter_avg    = 1'b0;
      w_cnt_dec      = 1'b0;
      w_acc          = 1'b0;
      w_push         = 1'b0;
      if (w_abort) begin
         w_state_nxt = ST_IDLE;
      end else if (w_start && (r_points != 16'd0)) begin
         w_state_nxt    = ST_SETTLE;
         w_restart      = 1'b1;
         w_enter_settle = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            ST_SETTLE: begin
               if (r_cnt == 32'd0) begin
                  w_state_nxt = ST_AVERAGE;
                  w_enter_avg = 1'b1;
               end else begin
                  w_cnt_dec = 1'b1;
               end
            end
            ST_AVERAGE: begin
               w_acc = 1'b1;
               if (r_cnt == 32'd0) w_state_nxt = ST_STORE;
               else w_cnt_dec = 1'b1;
            end
            ST_STORE: begin
               if (!w_fifo_full) begin
                  w_push = 1'b1;
                  if (!w_last) begin
                     w_step         = 1'b1;
                     w_state_nxt    = ST_SETTLE;
                     w_enter_settle = 1'b1;
                  end else if (w_loop) begin
                     w_reload       = 1'b1;
                     w_state_nxt    = ST_SETTLE;
                     w_enter_settle = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_state_nxt = ST_STORE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_freq       <= PHASEBITS'(0);
         r_freq_valid <= 1'b0;
         r_idx        <= 16'd0;
         r_cnt        <= 32'd0;
         r_isum       <= SUMBITS'(0);
         r_qsum       <= SUMBITS'(0);
      end else begin
         r_freq_valid <= 1'b0;
         if (w_restart || w_reload) begin
            r_freq       <= r_start_freq;
            r_idx        <= 16'd0;
            r_freq_valid <= 1'b1;
         end else if (w_step) begin
            r_freq       <= r_freq + r_step_freq;
            r_idx        <= r_idx + 16'd1;
            r_freq_valid <= 1'b1;
         end
         if (w_enter_settle) begin
            r_cnt  <= r_sleep;
            r_isum <= SUMBITS'(0);
            r_qsum <= SUMBITS'(0);
         end else if (w_enter_avg) begin
            r_cnt <= avg_preload(r_averages);
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 32'd1;
         end
         if (w_acc) begin
            r_isum <= r_isum + w_qi_ext;
            r_qsum <= r_qsum + w_qq_ext;
         end
      end
   end

   red_pitaya_iq_na_fifo #(.WIDTH(2*SUMBITS), .LOG2(FIFOLOG2)) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_flush (w_restart),
      .i_push  (w_push),
      .i_wdata ({r_isum, r_qsum}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_head_i = w_fifo_empty ? 64'd0 :
      {{(64-SUMBITS){w_fifo_rdata[2*SUMBITS-1]}}, w_fifo_rdata[2*SUMBITS-1:SUMBITS]};
   assign w_head_q = w_fifo_empty ? 64'd0 :
      {{(64-SUMBITS){w_fifo_rdata[SUMBITS-1]}}, w_fifo_rdata[SUMBITS-1:0]};

   always_comb begin
      w_rdata_nxt = 32'd0;
      case (addr)
         ADDR_CTRL:    w_rdata_nxt = {29'd0, w_loop, r_state};
         ADDR_START:   w_rdata_nxt = 32'(r_start_freq);
         ADDR_STEP:    w_rdata_nxt = 32'(r_step_freq);
         ADDR_POINTS:  w_rdata_nxt = {16'd0, r_points};
         ADDR_AVG:     w_rdata_nxt = r_averages;
         ADDR_SLEEP:   w_rdata_nxt = r_sleep;
         ADDR_STATUS:  w_rdata_nxt = {6'd0, w_fifo_full, r_busy, 8'(w_fifo_count), r_idx};
         ADDR_HEAD_IL: w_rdata_nxt = w_head_i[31:0];
         ADDR_HEAD_IH: w_rdata_nxt = w_head_i[63:32];
         ADDR_HEAD_QL: w_rdata_nxt = w_head_q[31:0];
         ADDR_HEAD_QH: w_rdata_nxt = w_head_q[63:32];
         ADDR_LOG2:    w_rdata_nxt = 32'(FIFOLOG2);
         default:      w_rdata_nxt = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ack        <= 1'b0;
         r_rdata      <= 32'd0;
         r_start_freq <= PHASEBITS'(0);
         r_step_freq  <= PHASEBITS'(0);
         r_points     <= 16'd0;
         r_averages   <= 32'd0;
         r_sleep      <= 32'd0;
      end else begin
         r_ack   <= wen | ren;
         r_rdata <= ren ? w_rdata_nxt : 32'd0;
         if (wen) begin
            case (addr)
               ADDR_START:  r_start_freq <= wdata[PHASEBITS-1:0];
               ADDR_STEP:   r_step_freq  <= wdata[PHASEBITS-1:0];
               ADDR_POINTS: r_points     <= wdata[15:0];
               ADDR_AVG:    r_averages   <= wdata;
               ADDR_SLEEP:  r_sleep      <= wdata;
               default:     ;
            endcase
         end
      end
   end

   assign freq_o       = r_freq;
   assign freq_valid_o = r_freq_valid;
   assign busy_o       = r_busy;
   assign ack          = r_ack;
   assign rdata        = r_rdata;

endmodule

// File: tb/tb_red_pitaya_iq_na_sweep.sv
// Self-checking bench for red_pitaya_iq_na_sweep: cycle-level sweep timing model,
// per-point sum model from logged quadratures, plus directed stall/abort/loop cases.
module tb_red_pitaya_iq_na_sweep;
   localparam logic [15:0] A_CTRL = 16'h0100, A_START = 16'h0104, A_STEP = 16'h0108;
   localparam logic [15:0] A_PTS = 16'h010C, A_AVG = 16'h0110, A_SLEEP = 16'h0114;
   localparam logic [15:0] A_STAT = 16'h0118, A_IL = 16'h0120, A_IH = 16'h0124;
   localparam logic [15:0] A_QL = 16'h0128, A_QH = 16'h012C, A_LOG2 = 16'h0200;

   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic [23:0] q1 = 24'd0, q2 = 24'd0;
   logic [31:0] freq_o;
   logic        freq_valid_o, busy_o, ack;
   logic [31:0] rdata;
   logic [15:0] addr = 16'd0;
   logic        wen = 1'b0, ren = 1'b0;
   logic [31:0] wdata = 32'd0;

   int vectors = 0, miscompares = 0, cyc = 0;

   red_pitaya_iq_na_sweep #(.LPFBITS(24), .PHASEBITS(32), .SUMBITS(62), .FIFOLOG2(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .quadrature1_i(q1), .quadrature2_i(q2),
      .freq_o(freq_o), .freq_valid_o(freq_valid_o), .busy_o(busy_o),
      .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata));

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // quadrature source; each value is logged under the cycle it is presented in
   bit     q_const = 1'b1;
   longint qi_log[int], qq_log[int];
   always begin
      @(posedge clk_i); #1;
      if (q_const) begin
         q1 = 24'd5; q2 = 24'hFFFFFD;
      end else begin
         q1 = 24'($urandom); q2 = 24'($urandom);
      end
      qi_log[cyc] = longint'($signed(q1));
      qq_log[cyc] = longint'($signed(q2));
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // sweep model: point k occupies P cycles starting at rel 1+k*P
   bit          model_on = 1'b0, m_active = 1'b0;
   int          m_start_cyc = 0, m_P = 1, m_points = 0;
   logic [31:0] m_start = 32'd0, m_step = 32'd0, m_last = 32'd0, m_prev_last = 32'd0;
   int          cfg_points = 0, cfg_sleep = 0, cfg_avg = 0;
   logic [31:0] cfg_start = 32'd0, cfg_step = 32'd0;

   always @(negedge clk_i) begin
      int rel;
      logic [31:0] ef;
      logic eb, ev;
      if (model_on) begin
         rel = cyc - m_start_cyc;
         if (m_active && rel >= 1 && rel <= m_points * m_P) begin
            eb = 1'b1;
            ev = (((rel - 1) % m_P) == 0);
            ef = m_start + 32'((rel - 1) / m_P) * m_step;
         end else begin
            eb = 1'b0;
            ev = 1'b0;
            ef = (m_active && rel >= 1) ? m_last : m_prev_last;
         end
         check("freq_o", {32'd0, freq_o}, {32'd0, ef});
         check("freq_valid_o", {63'd0, freq_valid_o}, {63'd0, ev});
         check("busy_o", {63'd0, busy_o}, {63'd0, eb});
      end
   end

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      @(posedge clk_i); #1;
      addr = a; wdata = d; wen = 1'b1;
      @(posedge clk_i); #1;
      wen = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
      @(posedge clk_i); #1;
      addr = a; ren = 1'b1;
      @(posedge clk_i); #1;
      ren = 1'b0;
      d = rdata;
      check("ack", {63'd0, ack}, 64'd1);
   endtask

   task automatic configure(input logic [31:0] st, input logic [31:0] sp, input int pts,
                            input int sl, input int av);
      cfg_start = st; cfg_step = sp; cfg_points = pts; cfg_sleep = sl; cfg_avg = av;
      bus_write(A_START, st);
      bus_write(A_STEP, sp);
      bus_write(A_PTS, 32'(pts));
      bus_write(A_SLEEP, 32'(sl));
      bus_write(A_AVG, 32'(av));
   endtask

   task automatic start_sweep();
      @(posedge clk_i); #1;
      addr = A_CTRL; wdata = 32'd1; wen = 1'b1;
      if (cfg_points != 0) begin
         m_prev_last = m_active ? m_last : m_prev_last;
         m_start_cyc = cyc;
         m_P         = 2 + cfg_sleep + ((cfg_avg == 0) ? 1 : cfg_avg);
         m_points    = cfg_points;
         m_start     = cfg_start;
         m_step      = cfg_step;
         m_last      = cfg_start + 32'(cfg_points - 1) * cfg_step;
         m_active    = 1'b1;
      end
      @(posedge clk_i); #1;
      wen = 1'b0;
   endtask

   function automatic logic [63:0] exp_sum(input bit is_q, input int k);
      longint s = 0;
      int first = m_start_cyc + 1 + k * m_P + 1 + cfg_sleep;
      int n = (cfg_avg == 0) ? 1 : cfg_avg;
      for (int c = first; c < first + n; c++) s += is_q ? qq_log[c] : qi_log[c];
      return 64'(s);
   endfunction

   task automatic drain_check(input int pts);
      logic [31:0] lo, hi, st;
      bus_read(A_STAT, st);
      check("status_after_sweep", {32'd0, st}, {32'd0, 8'd0, 8'(pts), 16'(pts - 1)});
      for (int k = 0; k < pts; k++) begin
         bus_read(A_IL, lo); bus_read(A_IH, hi);
         check("i_sum", {hi, lo}, exp_sum(1'b0, k));
         bus_read(A_QL, lo); bus_read(A_QH, hi);
         check("q_sum", {hi, lo}, exp_sum(1'b1, k));
      end
      bus_read(A_STAT, st);
      check("fifo_count_drained", {56'd0, st[23:16]}, 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, lo, hi;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      check("rst_freq", {32'd0, freq_o}, 64'd0);
      check("rst_valid", {63'd0, freq_valid_o}, 64'd0);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_ack", {63'd0, ack}, 64'd0);
      check("rst_rdata", {32'd0, rdata}, 64'd0);
      bus_read(A_CTRL, d);  check("rst_ctrl", {32'd0, d}, 64'd0);
      bus_read(A_START, d); check("rst_start", {32'd0, d}, 64'd0);
      bus_read(A_STAT, d);  check("rst_status", {32'd0, d}, 64'd0);
      bus_read(A_QH, d);    check("empty_head", {32'd0, d}, 64'd0);
      bus_read(A_LOG2, d);  check("fifolog2", {32'd0, d}, 64'd2);
      bus_read(16'h0300, d); check("unmapped", {32'd0, d}, 64'd0);
      model_on = 1'b1;

      // constant quadratures, 3 points
      q_const = 1'b1;
      configure(32'd1000, 32'd10, 3, 2, 4);
      start_sweep();
      repeat (m_points * m_P + 2) @(posedge clk_i);
      #1 check("final_freq_1020", {32'd0, freq_o}, 64'd1020);
      bus_read(A_STAT, d); check("status_3pts", {32'd0, d}, 64'h0003_0002);
      for (int k = 0; k < 3; k++) begin
         bus_read(A_IL, lo); bus_read(A_IH, hi); check("i_sum_const", {hi, lo}, 64'd20);
         bus_read(A_QL, lo); bus_read(A_QH, hi);
         check("q_sum_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
      end

      // zero points: start ignored
      configure(32'd77, 32'd1, 0, 1, 1);
      start_sweep();
      repeat (10) @(posedge clk_i);
      #1 check("pts0_busy", {63'd0, busy_o}, 64'd0);

      // frequency wrap
      configure(32'hFFFF_FFF0, 32'h20, 2, 0, 1);
      start_sweep();
      repeat (m_points * m_P + 2) @(posedge clk_i);
      #1 check("wrap_freq", {32'd0, freq_o}, 64'h10);
      drain_check(2);

      // randomized sweeps with random quadratures
      q_const = 1'b0;
      for (int t = 0; t < 6; t++) begin
         configure($urandom, $urandom, int'($urandom_range(3, 1)), int'($urandom_range(3, 0)),
                   int'($urandom_range(5, 0)));
         start_sweep();
         repeat (m_points * m_P + 2) @(posedge clk_i);
         drain_check(cfg_points);
      end

      // FIFO full stall (depth 4)
      model_on = 1'b0;
      q_const = 1'b1;
      configure(32'd100, 32'd1, 6, 0, 1);
      start_sweep();
      repeat (30) @(posedge clk_i);
      #1 check("stall_freq", {32'd0, freq_o}, 64'd104);
      check("stall_busy", {63'd0, busy_o}, 64'd1);
      bus_read(A_STAT, d); check("stall_status", {32'd0, d}, 64'h0304_0004);
      bus_read(A_QH, d);
      repeat (20) @(posedge clk_i);
      #1 check("resume_freq", {32'd0, freq_o}, 64'd105);
      bus_read(A_STAT, d); check("resume_status", {32'd0, d}, 64'h0304_0005);
      bus_write(A_CTRL, 32'd2);
      check("stall_abort_busy", {63'd0, busy_o}, 64'd0);

      // abort during averaging of the second point
      configure(32'd1000, 32'd10, 3, 1, 8);
      start_sweep();
      repeat (14) @(posedge clk_i);
      bus_write(A_CTRL, 32'd3);
      check("abort_busy", {63'd0, busy_o}, 64'd0);
      bus_read(A_CTRL, d); check("abort_state", {32'd0, d}, 64'd0);
      bus_read(A_STAT, d); check("abort_status", {32'd0, d}, 64'h0001_0001);
      bus_read(A_IL, d);   check("abort_i_lo", {32'd0, d}, 64'd40);
      bus_read(A_QH, d);   check("abort_q_hi", {32'd0, d}, 64'hFFFF_FFFF);
      bus_read(A_QH, d);   check("abort_pop_empty", {32'd0, d}, 64'd0);
      bus_read(A_STAT, d); check("abort_status2", {32'd0, d}, 64'h0000_0001);

`ifdef IQ_NA_SWEEP_LOOP_EN
      begin
         logic [31:0] pl[$];
         configure(32'd500, 32'd7, 2, 0, 1);
         bus_write(A_CTRL, 32'd5);
         repeat (12) begin
            @(negedge clk_i);
            if (freq_valid_o) pl.push_back(freq_o);
         end
         check("loop_npulses", 64'(pl.size()), 64'd4);
         if (pl.size() >= 4) begin
            check("loop_f0", {32'd0, pl[0]}, 64'd500);
            check("loop_f1", {32'd0, pl[1]}, 64'd507);
            check("loop_f2", {32'd0, pl[2]}, 64'd500);
            check("loop_f3", {32'd0, pl[3]}, 64'd507);
         end
         bus_write(A_CTRL, 32'd2);
         check("loop_abort_busy", {63'd0, busy_o}, 64'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
